// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit (0), DATA_W data bits LSB first,
// one parity bit, stop bit (1). Only cycles with bit_vld=1 advance the
// receiver. Each completed frame produces a one-cycle data_vld pulse with
// the word and its parity/framing error flags.
//
// Handshake: bit_in is consumed on every rising edge where bit_vld=1; there
// is no back-pressure. data_vld is a single-cycle strobe with no ready, and
// data_out/parity_err/frame_err stay stable until the next frame completes.
module parity_frame_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_vld,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [1:0]        o_dbg_state
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_acc;
    logic               r_perr;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_data_vld;
    logic               r_parity_err;
    logic               r_frame_err;
    logic [DATA_W-1:0]  w_shift_next;

    // Right shift with the new bit entering at the MSB, so the first (LSB)
    // data bit ends up at bit 0 after DATA_W shifts. Written as shifts so it
    // stays legal for DATA_W=1.
    always_comb begin
        w_shift_next = (r_shift >> 1) | (DATA_W'(bit_in) << (DATA_W - 1));
    end

    // Receiver FSM and datapath; everything but the data_vld strobe holds
    // while bit_vld is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_acc        <= 1'b0;
            r_perr       <= 1'b0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_vld   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_vld <= 1'b0;
            if (bit_vld) begin
                case (r_state)
                    S_IDLE: begin
                        // A 1 on the line is idle; only a 0 opens a frame.
                        if (!bit_in) begin
                            r_state <= S_DATA;
                            r_shift <= '0;
                            r_cnt   <= '0;
                            r_acc   <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        r_shift <= w_shift_next;
                        r_acc   <= r_acc ^ bit_in;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        // r_cnt indexes the bit being received now.
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_PAR;
                        end
                    end
                    S_PAR: begin
                        r_perr  <= r_acc ^ bit_in ^ PARITY_ODD;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        // Word is delivered even with errors; flags qualify it.
                        r_data_out   <= r_shift;
                        r_parity_err <= r_perr;
                        r_frame_err  <= ~bit_in;
                        r_data_vld   <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out    = r_data_out;
    assign data_vld    = r_data_vld;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule
